// File: rtl/seg7_pkg.sv
// Shared 7-segment glyph type, glyph constants and code-to-glyph lookup.
// Segment order is {a,b,c,d,e,f,g}, logical polarity (1 = lit).
package seg7_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_BLANK = 7'b0000000;
  localparam seg_t SEG_0 = 7'b1111110;
  localparam seg_t SEG_1 = 7'b0110000;
  localparam seg_t SEG_2 = 7'b1101101;
  localparam seg_t SEG_3 = 7'b1111001;
  localparam seg_t SEG_4 = 7'b0110011;
  localparam seg_t SEG_5 = 7'b1011011;
  localparam seg_t SEG_6 = 7'b1011111;
  localparam seg_t SEG_7 = 7'b1110000;
  localparam seg_t SEG_8 = 7'b1111111;
  localparam seg_t SEG_9 = 7'b1111011;
  localparam seg_t SEG_A = 7'b1110111;
  localparam seg_t SEG_B = 7'b0011111;
  localparam seg_t SEG_C = 7'b1001110;
  localparam seg_t SEG_D = 7'b0111101;
  localparam seg_t SEG_E = 7'b1001111;
  localparam seg_t SEG_F = 7'b1000111;

  function automatic seg_t seg7_glyph(
    input logic [3:0] code,
    input logic       hex_en
  );
    seg_t g;
    g = SEG_BLANK;
    case (code)
      4'h0: g = SEG_0;
      4'h1: g = SEG_1;
      4'h2: g = SEG_2;
      4'h3: g = SEG_3;
      4'h4: g = SEG_4;
      4'h5: g = SEG_5;
      4'h6: g = SEG_6;
      4'h7: g = SEG_7;
      4'h8: g = SEG_8;
      4'h9: g = SEG_9;
      4'hA: g = hex_en ? SEG_A : SEG_BLANK;
      4'hB: g = hex_en ? SEG_B : SEG_BLANK;
      4'hC: g = hex_en ? SEG_C : SEG_BLANK;
      4'hD: g = hex_en ? SEG_D : SEG_BLANK;
      4'hE: g = hex_en ? SEG_E : SEG_BLANK;
      4'hF: g = hex_en ? SEG_F : SEG_BLANK;
      default: g = SEG_BLANK;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational digit code to 7-segment glyph decoder.
// Codes 10..15 are blank unless hex_en is set.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] code,
  input  logic       hex_en,
  output seg_t       glyph
);

  assign glyph = seg7_glyph(code, hex_en);

endmodule

// File: rtl/bcd7seg_scan.sv
// Multiplexed N-digit 7-segment scanner with frame-synchronous update,
// leading-zero blanking, anti-ghost guard time and pin polarity control.
module bcd7seg_scan
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int DIV            = 50000,
  parameter int GUARD          = 2,
  parameter int HEX_EN         = 0,
  parameter int SEG_ACTIVE_LOW = 0,
  parameter int AN_ACTIVE_LOW  = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    upd_valid,
  output logic                    upd_ready,
  input  logic [4*NUM_DIGITS-1:0] upd_digits,
  input  logic [NUM_DIGITS-1:0]   upd_dp,
  input  logic                    lzb_en,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done
);

  localparam int PW = $clog2(DIV);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam int DW = 4 * NUM_DIGITS;

  localparam logic [PW-1:0] PLAST  = PW'(DIV - 1);
  localparam logic [PW-1:0] PGUARD = PW'(GUARD);
  localparam logic [IW-1:0] ILAST  = IW'(NUM_DIGITS - 1);

  localparam logic SEG_INV = (SEG_ACTIVE_LOW != 0);
  localparam logic AN_INV  = (AN_ACTIVE_LOW != 0);
  localparam logic HEX_ON  = (HEX_EN != 0);

  localparam logic [NUM_DIGITS-1:0] AN_ONE =
    {{(NUM_DIGITS-1){1'b0}}, 1'b1};

  logic [PW-1:0]         pcnt;
  logic [IW-1:0]         idx;
  logic                  tick;
  logic                  wrap;
  logic                  fire;
  logic [DW-1:0]         pend_dig;
  logic [NUM_DIGITS-1:0] pend_dp;
  logic                  pend_full;
  logic [DW-1:0]         img_dig;
  logic [NUM_DIGITS-1:0] img_dp;
  logic                  shown;
  logic [NUM_DIGITS-1:0] lead;
  logic [3:0]            code;
  seg_t                  glyph;
  logic                  blank;
  seg_t                  seg_q;
  logic                  dp_q;
  logic [NUM_DIGITS-1:0] an_q;

  assign tick      = (pcnt == PLAST);
  assign wrap      = tick && (idx == ILAST);
  assign upd_ready = !pend_full;
  assign fire      = upd_valid && !pend_full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt <= '0;
      idx  <= '0;
    end else begin
      pcnt <= tick ? '0 : pcnt + 1'b1;
      if (tick) idx <= wrap ? '0 : idx + 1'b1;
    end
  end

  // Transfer and capture are exclusive: capture needs an empty buffer,
  // transfer needs a full one, so a capture on the wrap tick waits a frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_dig  <= '0;
      pend_dp   <= '0;
      pend_full <= 1'b0;
      img_dig   <= '0;
      img_dp    <= '0;
      shown     <= 1'b0;
    end else if (wrap && pend_full) begin
      img_dig   <= pend_dig;
      img_dp    <= pend_dp;
      shown     <= 1'b1;
      pend_full <= 1'b0;
    end else if (fire) begin
      pend_dig  <= upd_digits;
      pend_dp   <= upd_dp;
      pend_full <= 1'b1;
    end
  end

  // lead[k]: digits NUM_DIGITS-1 down to k are all zero
  always_comb begin
    lead = '0;
    lead[NUM_DIGITS-1] = (img_dig[DW-1 -: 4] == 4'd0);
    for (int k = NUM_DIGITS - 2; k >= 0; k--) begin
      lead[k] = lead[k+1] && (img_dig[4*k +: 4] == 4'd0);
    end
  end

  assign code  = img_dig[{idx, 2'b00} +: 4];
  assign blank = !shown || (lzb_en && (idx != '0) && lead[idx]);

  seg7_decode u_dec (
    .code   (code),
    .hex_en (HEX_ON),
    .glyph  (glyph)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q      <= SEG_BLANK;
      dp_q       <= 1'b0;
      an_q       <= '0;
      frame_done <= 1'b0;
    end else begin
      seg_q      <= blank ? SEG_BLANK : glyph;
      dp_q       <= img_dp[idx];
      an_q       <= (pcnt < PGUARD) ? '0 : (AN_ONE << idx);
      frame_done <= wrap;
    end
  end

  assign seg = seg_q ^ {7{SEG_INV}};
  assign dp  = dp_q ^ SEG_INV;
  assign an  = an_q ^ {NUM_DIGITS{AN_INV}};

endmodule

// File: tb/tb_bcd7seg_scan.sv
// Directed bench for bcd7seg_scan: 4 digits, 8-cycle slots, 2 guard cycles.
// A second instance with hex glyphs and inverted segment pins shares stimulus.
module tb_bcd7seg_scan;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        upd_valid = 1'b0;
  logic [15:0] upd_digits = '0;
  logic [3:0]  upd_dp = '0;
  logic        lzb_en = 1'b0;

  logic        upd_ready, dp, frame_done;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        upd_ready2, dp2, frame_done2;
  logic [6:0]  seg2;
  logic [3:0]  an2;

  int checks = 0;
  int errors = 0;

  logic [6:0] seg_j [32];
  logic [6:0] seg2_j[32];
  logic       dp_j  [32];
  logic       dp2_j [32];
  logic [3:0] an_j  [32];
  logic       rdy_j [32];
  logic       fd_j  [32];

  bcd7seg_scan #(
    .NUM_DIGITS(4), .DIV(8), .GUARD(2),
    .HEX_EN(0), .SEG_ACTIVE_LOW(0), .AN_ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .upd_valid(upd_valid), .upd_ready(upd_ready),
    .upd_digits(upd_digits), .upd_dp(upd_dp),
    .lzb_en(lzb_en),
    .seg(seg), .dp(dp), .an(an),
    .frame_done(frame_done)
  );

  bcd7seg_scan #(
    .NUM_DIGITS(4), .DIV(8), .GUARD(2),
    .HEX_EN(1), .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1)
  ) dut2 (
    .clk(clk), .rst_n(rst_n),
    .upd_valid(upd_valid), .upd_ready(upd_ready2),
    .upd_digits(upd_digits), .upd_dp(upd_dp),
    .lzb_en(lzb_en),
    .seg(seg2), .dp(dp2), .an(an2),
    .frame_done(frame_done2)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] exp_an(input int j);
    logic [3:0] one;
    one = 4'b0001;
    if ((j % 8) < 2) return 4'b1111;
    return ~(one << (j / 8));
  endfunction

  // Record one full frame starting right after a frame_done pulse.
  // The handshake inputs switch to the given values after the first edge.
  task automatic scan_frame(
    input logic        nv,
    input logic [15:0] nd,
    input logic [3:0]  np
  );
    for (int j = 0; j < 32; j++) begin
      step();
      seg_j[j]  = seg;
      seg2_j[j] = seg2;
      dp_j[j]   = dp;
      dp2_j[j]  = dp2;
      an_j[j]   = an;
      rdy_j[j]  = upd_ready;
      fd_j[j]   = frame_done;
      if (j == 0) begin
        upd_valid  = nv;
        upd_digits = nd;
        upd_dp     = np;
      end
    end
  endtask

  task automatic wait_fd(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!frame_done && n < 200);
  endtask

  task automatic test_reset();
    int n;
    repeat (3) step();
    checks++;
    if (an !== 4'b1111 || seg !== 7'b0 || dp !== 1'b0) begin
      errors++;
      $display("FAIL reset_pins an=%b seg=%b dp=%b want 1111 0000000 0",
               an, seg, dp);
    end
    checks++;
    if (upd_ready !== 1'b1 || frame_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_hs ready=%b fd=%b want 1 0", upd_ready, frame_done);
    end
    checks++;
    if (seg2 !== 7'h7F || dp2 !== 1'b1 || an2 !== 4'b1111) begin
      errors++;
      $display("FAIL reset_inv seg2=%b dp2=%b an2=%b want 1111111 1 1111",
               seg2, dp2, an2);
    end
    rst_n = 1'b1;
    wait_fd(n);
    checks++;
    if (n != 32) begin
      errors++;
      $display("FAIL first_frame_done got %0d cycles want 32", n);
    end
    scan_frame(1'b0, 16'h0, 4'h0);
    for (int j = 0; j < 32; j++) begin
      checks++;
      if (seg_j[j] !== 7'b0 || an_j[j] !== exp_an(j) || dp_j[j] !== 1'b0) begin
        errors++;
        $display("FAIL blank_frame j=%0d seg=%b an=%b dp=%b want 0000000 %b 0",
                 j, seg_j[j], an_j[j], dp_j[j], exp_an(j));
      end
      checks++;
      if (fd_j[j] !== (j == 31)) begin
        errors++;
        $display("FAIL fd_period j=%0d got %b want %b", j, fd_j[j], j == 31);
      end
    end
  endtask

  task automatic test_update();
    logic [6:0] es[4];
    logic [3:0] ed;
    lzb_en     = 1'b0;
    upd_valid  = 1'b1;
    upd_digits = 16'h0123;
    upd_dp     = 4'b0010;
    scan_frame(1'b0, 16'h0123, 4'b0010);
    for (int j = 0; j < 32; j++) begin
      checks++;
      if (seg_j[j] !== 7'b0) begin
        errors++;
        $display("FAIL upd_no_tear j=%0d seg=%b want 0000000", j, seg_j[j]);
      end
      checks++;
      if (rdy_j[j] !== (j == 31)) begin
        errors++;
        $display("FAIL upd_ready j=%0d got %b want %b", j, rdy_j[j], j == 31);
      end
    end
    scan_frame(1'b0, 16'h0123, 4'b0010);
    es = '{7'b1111001, 7'b1101101, 7'b0110000, 7'b1111110};
    ed = 4'b0010;
    for (int j = 0; j < 32; j++) begin
      checks++;
      if (seg_j[j] !== es[j/8] || dp_j[j] !== ed[j/8]) begin
        errors++;
        $display("FAIL upd_show j=%0d seg=%b dp=%b want %b %b",
                 j, seg_j[j], dp_j[j], es[j/8], ed[j/8]);
      end
      checks++;
      if (an_j[j] !== exp_an(j)) begin
        errors++;
        $display("FAIL upd_an j=%0d got %b want %b", j, an_j[j], exp_an(j));
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [6:0] ea[4];
    logic [6:0] eb[4];
    upd_valid  = 1'b1;
    upd_digits = 16'h4567;
    upd_dp     = 4'b0001;
    scan_frame(1'b1, 16'h0089, 4'b1000);
    for (int j = 0; j < 32; j++) begin
      checks++;
      if (rdy_j[j] !== (j == 31)) begin
        errors++;
        $display("FAIL b2b_stall j=%0d ready=%b want %b", j, rdy_j[j], j == 31);
      end
    end
    checks++;
    if (seg_j[31] !== 7'b1111110 || seg_j[0] !== 7'b1111001) begin
      errors++;
      $display("FAIL b2b_old seg0=%b seg31=%b want 1111001 1111110",
               seg_j[0], seg_j[31]);
    end
    scan_frame(1'b0, 16'h0089, 4'b1000);
    ea = '{7'b1110000, 7'b1011111, 7'b1011011, 7'b0110011};
    for (int j = 0; j < 32; j++) begin
      checks++;
      if (seg_j[j] !== ea[j/8] || dp_j[j] !== (j < 8)) begin
        errors++;
        $display("FAIL b2b_first j=%0d seg=%b dp=%b want %b %b",
                 j, seg_j[j], dp_j[j], ea[j/8], j < 8);
      end
    end
    checks++;
    if (rdy_j[0] !== 1'b0 || rdy_j[31] !== 1'b1) begin
      errors++;
      $display("FAIL b2b_second_accept r0=%b r31=%b want 0 1",
               rdy_j[0], rdy_j[31]);
    end
    scan_frame(1'b0, 16'h0089, 4'b1000);
    eb = '{7'b1111011, 7'b1111111, 7'b1111110, 7'b1111110};
    for (int j = 0; j < 32; j++) begin
      checks++;
      if (seg_j[j] !== eb[j/8] || dp_j[j] !== (j >= 24)) begin
        errors++;
        $display("FAIL b2b_second j=%0d seg=%b dp=%b want %b %b",
                 j, seg_j[j], dp_j[j], eb[j/8], j >= 24);
      end
    end
  endtask

  task automatic test_lzb();
    logic [6:0] e5[4];
    lzb_en     = 1'b1;
    upd_valid  = 1'b1;
    upd_digits = 16'h0005;
    upd_dp     = 4'b0100;
    scan_frame(1'b0, 16'h0005, 4'b0100);
    scan_frame(1'b0, 16'h0005, 4'b0100);
    e5 = '{7'b1011011, 7'b0, 7'b0, 7'b0};
    for (int s = 0; s < 4; s++) begin
      checks++;
      if (seg_j[s*8+4] !== e5[s] || dp_j[s*8+4] !== (s == 2)) begin
        errors++;
        $display("FAIL lzb_0005 slot=%0d seg=%b dp=%b want %b %b",
                 s, seg_j[s*8+4], dp_j[s*8+4], e5[s], s == 2);
      end
    end
    upd_valid  = 1'b1;
    upd_digits = 16'h0000;
    upd_dp     = 4'b0000;
    scan_frame(1'b0, 16'h0000, 4'b0000);
    scan_frame(1'b0, 16'h0000, 4'b0000);
    for (int s = 0; s < 4; s++) begin
      checks++;
      if (seg_j[s*8+4] !== ((s == 0) ? 7'b1111110 : 7'b0)) begin
        errors++;
        $display("FAIL lzb_0000 slot=%0d seg=%b want %b",
                 s, seg_j[s*8+4], (s == 0) ? 7'b1111110 : 7'b0);
      end
    end
    lzb_en = 1'b0;
    scan_frame(1'b0, 16'h0000, 4'b0000);
    for (int s = 0; s < 4; s++) begin
      checks++;
      if (seg_j[s*8+4] !== 7'b1111110) begin
        errors++;
        $display("FAIL lzb_off slot=%0d seg=%b want 1111110",
                 s, seg_j[s*8+4]);
      end
    end
  endtask

  task automatic test_hex();
    logic [6:0] e2[4];
    upd_valid  = 1'b1;
    upd_digits = 16'hFA0B;
    upd_dp     = 4'b0000;
    scan_frame(1'b0, 16'hFA0B, 4'b0000);
    scan_frame(1'b0, 16'hFA0B, 4'b0000);
    e2 = '{7'b1100000, 7'b0000001, 7'b0001000, 7'b0111000};
    for (int s = 0; s < 4; s++) begin
      checks++;
      if (seg_j[s*8+4] !== ((s == 1) ? 7'b1111110 : 7'b0)) begin
        errors++;
        $display("FAIL hex_off slot=%0d seg=%b want %b",
                 s, seg_j[s*8+4], (s == 1) ? 7'b1111110 : 7'b0);
      end
      checks++;
      if (seg2_j[s*8+4] !== e2[s] || dp2_j[s*8+4] !== 1'b1) begin
        errors++;
        $display("FAIL hex_inv slot=%0d seg2=%b dp2=%b want %b 1",
                 s, seg2_j[s*8+4], dp2_j[s*8+4], e2[s]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int n;
    upd_valid  = 1'b1;
    upd_digits = 16'h1111;
    upd_dp     = 4'b1111;
    step();
    upd_valid = 1'b0;
    checks++;
    if (upd_ready !== 1'b0) begin
      errors++;
      $display("FAIL mid_pend ready=%b want 0", upd_ready);
    end
    repeat (11) step();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (an !== 4'b1111 || seg !== 7'b0 || dp !== 1'b0 || upd_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_async an=%b seg=%b dp=%b ready=%b want 1111 0 0 1",
               an, seg, dp, upd_ready);
    end
    repeat (3) step();
    rst_n = 1'b1;
    wait_fd(n);
    checks++;
    if (n != 32) begin
      errors++;
      $display("FAIL mid_frame_done got %0d cycles want 32", n);
    end
    for (int f = 0; f < 2; f++) begin
      scan_frame(1'b0, 16'h1111, 4'b1111);
      for (int j = 0; j < 32; j++) begin
        checks++;
        if (seg_j[j] !== 7'b0 || dp_j[j] !== 1'b0 || rdy_j[j] !== 1'b1) begin
          errors++;
          $display("FAIL mid_discard f=%0d j=%0d seg=%b dp=%b ready=%b want 0 0 1",
                   f, j, seg_j[j], dp_j[j], rdy_j[j]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_update();
    test_back_to_back();
    test_lzb();
    test_hex();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
